// File: rtl/half_arb_pkg.sv
// Shared types and helpers for the fp16 adder arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package half_arb_pkg;

    typedef logic [15:0] half_t;

    localparam half_t FP16_POS_ZERO = 16'h0000;
    localparam half_t FP16_NEG_ZERO = 16'h8000;

    // Width of a requester index. A single-bit tag is kept even for one requester
    // so that tag vectors never collapse to zero width.
    function automatic int tag_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/half_arb_tag_fifo.sv
// In-order FIFO of requester tags for adds issued but not yet returned.
// Latency: pop_dat shows the head combinationally; push is visible one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module half_arb_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;

    // Pointers carry one wrap bit so equal indices can be told apart as full vs empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_dat = mem_q[rd_q[AW-1:0]];

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_q[AW-1:0]] <= push_dat;
        end
    end

    // Pointer update; reset discards every queued tag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/half_add_arbiter.sv
// Round-robin share of one pipelined fp16 adder among NREQ requesters, tags routing sums back.
// Latency: accept -> add_in_valid 1 cycle; add_out_valid -> resp_valid 1 cycle (adder latency + 2 total).
// Backpressure: req_ready drops while MAX_INFLIGHT adds are outstanding; responses cannot be stalled.
// Optional: define HALF_ARB_STATS_EN to add the grant_cnt per-requester accept counters.
module half_add_arbiter
    import half_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic  [NREQ-1:0]      req_valid,
    output logic  [NREQ-1:0]      req_ready,
    input  half_t [NREQ-1:0]      req_a,
    input  half_t [NREQ-1:0]      req_b,
    output logic  [NREQ-1:0]      resp_valid,
    output half_t                 resp_c,
    output logic                  add_in_valid,
    output half_t                 add_a,
    output half_t                 add_b,
    input  logic                  add_out_valid,
    input  half_t                 add_c,
    output logic                  err_unexp
`ifdef HALF_ARB_STATS_EN
    ,
    output logic  [NREQ-1:0][15:0] grant_cnt
`endif
);

    localparam int TW = tag_w(NREQ);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [TW-1:0]   last_grant_q;
    logic [TW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_found;
    logic            slot_free;
    logic            accept;

    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   inflight_d;

    logic            add_in_valid_q;
    half_t           add_a_q;
    half_t           add_b_q;

    logic [NREQ-1:0] resp_valid_q;
    logic [NREQ-1:0] resp_valid_d;
    half_t           resp_c_q;
    logic            err_q;

    logic            fifo_empty;
    logic            fifo_full;
    logic [TW-1:0]   ret_tag;
    logic            ret_ok;
    logic            ret_bad;

    // A full window blocks grants even when a return lands in the same cycle;
    // the freed slot becomes usable one cycle later.
    assign slot_free = (inflight_q < MAX_CNT);

    // Round-robin: first pass looks above the last winner, second pass wraps to 0.
    always_comb begin
        gnt       = '0;
        gnt_idx   = last_grant_q;
        gnt_found = 1'b0;
        if (slot_free) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_found && req_valid[i] && (TW'(i) > last_grant_q)) begin
                    gnt_found = 1'b1;
                    gnt[i]    = 1'b1;
                    gnt_idx   = TW'(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_found && req_valid[i] && (TW'(i) <= last_grant_q)) begin
                    gnt_found = 1'b1;
                    gnt[i]    = 1'b1;
                    gnt_idx   = TW'(i);
                end
            end
        end
    end

    // Nothing is granted while reset is held, whatever the requesters present.
    assign req_ready = rstn ? gnt : '0;
    assign accept    = |(req_valid & req_ready);

    // A return with no outstanding tag is flagged, never routed.
    assign ret_ok  = add_out_valid && !fifo_empty;
    assign ret_bad = add_out_valid &&  fifo_empty;

    half_arb_tag_fifo #(
        .W     (TW),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (accept),
        .push_dat (gnt_idx),
        .pop      (ret_ok),
        .pop_dat  (ret_tag),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Outstanding count: accept and return in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !ret_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && ret_ok) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Expand the returning tag into the one-hot response strobe.
    always_comb begin
        resp_valid_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid_d[i] = ret_ok && (ret_tag == TW'(i));
        end
    end

    // Issue stage: capture the winner's operands untouched; they hold when idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q   <= TW'(NREQ - 1);
            add_in_valid_q <= 1'b0;
            add_a_q        <= FP16_POS_ZERO;
            add_b_q        <= FP16_POS_ZERO;
        end else begin
            add_in_valid_q <= accept;
            if (accept) begin
                last_grant_q <= gnt_idx;
                add_a_q      <= req_a[gnt_idx];
                add_b_q      <= req_b[gnt_idx];
            end
        end
    end

    // Return stage: one-cycle strobe to the owner, sum held on the shared bus.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid_q <= '0;
            resp_c_q     <= FP16_POS_ZERO;
        end else begin
            resp_valid_q <= resp_valid_d;
            if (ret_ok) begin
                resp_c_q <= add_c;
            end
        end
    end

    // Outstanding-add counter and sticky unexpected-return flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (ret_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign add_in_valid = add_in_valid_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_c       = resp_c_q;
    assign err_unexp    = err_q;

`ifdef HALF_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt_q;

    // Per-requester accept counters, saturating instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule
